// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: sync hunt, length-prefixed frame parse,
// XOR-checked payload buffering and valid/ready release of verified payloads.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       drop
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_t;

  state_t          state, nxt;
  logic [LW-1:0]   len, idx, rd_idx;
  logic [7:0]      chk;
  logic [TW-1:0]   tcnt;
  logic [7:0]      mem [MAX_LEN];

  logic            len_ok, timed, to_hit, hs;
  logic            p_len, p_chk, p_to, p_drop;

  assign len_ok = (rx_data != 8'h00) && (int'(rx_data) <= MAX_LEN);
  assign timed  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  // Counter is held below TIMEOUT_CLKS-1; the edge that would reach it aborts.
  assign to_hit = timed && !rx_done && (tcnt == TW'(TIMEOUT_CLKS - 2));
  assign hs     = (state == S_SEND) && out_ready;

  assign out_valid = (state == S_SEND);
  assign out_last  = (state == S_SEND) && (rd_idx == len - LW'(1));
  assign out_data  = (state == S_SEND) ? mem[rd_idx[AW-1:0]] : 8'h00;
  assign busy      = (state != S_HUNT);

  always_comb begin
    nxt    = state;
    p_len  = 1'b0;
    p_chk  = 1'b0;
    p_to   = 1'b0;
    p_drop = 1'b0;
    case (state)
      S_HUNT:    if (rx_done && rx_data == SYNC_BYTE) nxt = S_LEN;
      S_LEN:     if (rx_done) begin
                   if (len_ok) nxt = S_PAYLOAD;
                   else begin
                     nxt   = S_HUNT;
                     p_len = 1'b1;
                   end
                 end
      S_PAYLOAD: if (rx_done && idx == len - LW'(1)) nxt = S_CHK;
      S_CHK:     if (rx_done) begin
                   if (rx_data == chk) nxt = S_SEND;
                   else begin
                     nxt   = S_HUNT;
                     p_chk = 1'b1;
                   end
                 end
      S_SEND:    begin
                   p_drop = rx_done;
                   if (hs && out_last) nxt = S_HUNT;
                 end
      default:   nxt = S_HUNT;
    endcase
    if (to_hit) begin
      nxt  = S_HUNT;
      p_to = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HUNT;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      chk         <= 8'h00;
      tcnt        <= '0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state       <= nxt;
      err_len     <= p_len;
      err_chk     <= p_chk;
      err_timeout <= p_to;
      drop        <= p_drop;
      if (!timed || rx_done || nxt != state) tcnt <= '0;
      else                                   tcnt <= tcnt + TW'(1);
      if (state == S_LEN && rx_done && len_ok) begin
        len <= rx_data[LW-1:0];
        chk <= rx_data;
        idx <= '0;
      end
      if (state == S_PAYLOAD && rx_done) begin
        chk <= chk ^ rx_data;
        idx <= idx + LW'(1);
      end
      if (state == S_CHK) rd_idx <= '0;
      else if (hs)        rd_idx <= rd_idx + LW'(1);
    end
  end

  // Payload storage needs no reset; it is only read after being written.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_done) mem[idx[AW-1:0]] <= rx_data;
  end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: good/bad frames, length limits,
// timeout, backpressure with drops, and asynchronous reset mid-frame.
module tb_uart_rx_pkt_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_valid, out_ready, out_last, busy;
  logic [7:0] out_data;
  logic       err_len, err_chk, err_timeout, drop;

  int checks = 0;
  int failures = 0;
  int n_len = 0, n_chk = 0, n_to = 0, n_drop = 0;

  uart_rx_pkt_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(8), .TIMEOUT_CLKS(1024)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err_len(err_len), .err_chk(err_chk),
    .err_timeout(err_timeout), .drop(drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_len)     n_len++;
    if (err_chk)     n_chk++;
    if (err_timeout) n_to++;
    if (drop)        n_drop++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is taken at the following posedge.
  task automatic sb(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, "_data"},  {24'b0, out_data},  {24'b0, d});
    check({tag, "_last"},  {31'b0, out_last},  {31'b0, l});
  endtask

  initial begin
    int k;
    logic [7:0] exp8;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_errs", {28'b0, err_len, err_chk, err_timeout, drop}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame, 3 bytes with ready held high
    sb(8'hA5); sb(8'h03); sb(8'h11); sb(8'h22); sb(8'h33);
    check("good_busy_mid", {31'b0, busy}, 1);
    sb(8'h03);
    chk_out("good0", 1'b1, 8'h11, 1'b0);
    @(negedge clk); chk_out("good1", 1'b1, 8'h22, 1'b0);
    @(negedge clk); chk_out("good2", 1'b1, 8'h33, 1'b1);
    @(negedge clk); check("good_busy_end", {31'b0, busy}, 0);
    check("good_valid_end", {31'b0, out_valid}, 0);
    check("good_no_err", n_len + n_chk + n_to + n_drop, 0);

    // Bad checksum (02^10^20 = 32, sent 31), then a 1-byte frame
    sb(8'hA5); sb(8'h02); sb(8'h10); sb(8'h20); sb(8'h31);
    check("badchk_pulse", {31'b0, err_chk}, 1);
    check("badchk_busy", {31'b0, busy}, 0);
    check("badchk_valid", {31'b0, out_valid}, 0);
    @(negedge clk); check("badchk_pulse_end", {31'b0, err_chk}, 0);
    sb(8'hA5); sb(8'h01); sb(8'h7E); sb(8'h7F);
    chk_out("one", 1'b1, 8'h7E, 1'b1);
    @(negedge clk); check("one_busy_end", {31'b0, busy}, 0);

    // Junk ignored, then length 0 and length 9
    sb(8'h00); sb(8'hFF); sb(8'h5A);
    check("junk_busy", {31'b0, busy}, 0);
    check("junk_silent", n_len + n_chk + n_to + n_drop, 1);
    sb(8'hA5); sb(8'h00);
    check("len0_pulse", {31'b0, err_len}, 1);
    check("len0_busy", {31'b0, busy}, 0);
    sb(8'hA5); sb(8'h09);
    check("len9_pulse", {31'b0, err_len}, 1);
    check("len9_busy", {31'b0, busy}, 0);

    // MAX_LEN frame: payload 01..08, chk = 08 ^ (01^..^08) = 00
    sb(8'hA5); sb(8'h08);
    for (int i = 1; i <= 8; i++) sb(8'(i));
    sb(8'h00);
    for (int i = 1; i <= 8; i++) begin
      exp8 = 8'(i);
      chk_out("max", 1'b1, exp8, i == 8);
      @(negedge clk);
    end
    check("max_busy_end", {31'b0, busy}, 0);

    // Inter-byte timeout
    sb(8'hA5); sb(8'h02); sb(8'h11);
    k = 0;
    while (k < 1100 && !err_timeout) begin
      @(negedge clk);
      k++;
    end
    check("to_idle_clks", k, 1023);
    check("to_busy", {31'b0, busy}, 0);
    sb(8'hA5); sb(8'h01); sb(8'h55); sb(8'h54);
    chk_out("after_to", 1'b1, 8'h55, 1'b1);
    @(negedge clk);

    // Backpressure with drops (chk = 02^AA^BB = 13)
    out_ready = 1'b0;
    sb(8'hA5); sb(8'h02); sb(8'hAA); sb(8'hBB); sb(8'h13);
    for (int i = 0; i < 5; i++) begin
      chk_out("hold", 1'b1, 8'hAA, 1'b0);
      @(negedge clk);
    end
    sb(8'hA5);
    check("drop_pulse", {31'b0, drop}, 1);
    chk_out("after_drop", 1'b1, 8'hAA, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp1", 1'b1, 8'hBB, 1'b1);
    sb(8'h5A);
    check("drop_last_pulse", {31'b0, drop}, 1);
    check("drop_last_busy", {31'b0, busy}, 0);
    @(negedge clk);
    check("drop_last_idle", {31'b0, busy}, 0);

    // Async reset mid-payload
    sb(8'hA5); sb(8'h04); sb(8'h01); sb(8'h02);
    check("mid_busy", {31'b0, busy}, 1);
    #2 rst = 1'b1;
    #1 check("arst_busy", {31'b0, busy}, 0);
    chk_out("arst", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb(8'hA5); sb(8'h01); sb(8'h55); sb(8'h54);
    chk_out("post_rst", 1'b1, 8'h55, 1'b1);
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 0);

    check("cnt_len", n_len, 2);
    check("cnt_chk", n_chk, 1);
    check("cnt_to", n_to, 1);
    check("cnt_drop", n_drop, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
